fetch_queue_unit: RTL and testbench

- IF-stage front end for the pipelined CPU. Replaces the free-running PC/instruction-memory pairing with a decoupled fetch engine.
- Owns the PC and issues in-order requests to a variable-latency instruction memory. Buffers the returned instructions with their PCs in a prefetch FIFO and presents one instruction per cycle to the IF/ID register.
- Supports an ID-side stall and a branch redirect, which flushes all buffered and in-flight instructions.

---
 rtl/fetch_queue_unit.sv | 88 ++++++++
 tb/tb_fetch_queue_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Decoupled IF-stage fetch engine: owns the PC, issues in-order requests to a
// variable-latency instruction memory and buffers responses in a prefetch FIFO.
module fetch_queue_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_addr,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pcaddr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [63:0]   pc_q, resp_pc;
  logic [31:0]   instr_mem [DEPTH];
  logic [63:0]   pc_mem    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [CW:0]   inflight;
  logic [63:0]   redir_pc;
  logic          grant, rv_eff, dropping, push, pop;

  // Queued plus in-flight never exceeds DEPTH, so a response always has a slot.
  assign inflight  = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = ~rst & ~redirect & (inflight < DEPTH_W);
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;
  // A response with nothing outstanding belongs to a pre-reset request.
  assign rv_eff    = imem_rvalid & (outstanding != '0);
  assign dropping  = (drop_cnt != '0);
  assign push      = ~rst & ~redirect & rv_eff & ~dropping;
  assign pop       = ~rst & ~redirect & if_valid & ~id_stall;
  assign redir_pc  = {redirect_addr[63:2], 2'b00};

  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign if_pcaddr = if_valid ? pc_mem[rd_ptr]    : 64'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // Everything still in flight now belongs to the wrong path.
      pc_q        <= redir_pc;
      resp_pc     <= redir_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(rv_eff);
      drop_cnt    <= drop_cnt + outstanding - CW'(rv_eff);
    end else begin
      if (grant) pc_q <= pc_q + 64'd4;
      outstanding <= outstanding + CW'(grant) - CW'(rv_eff);
      if (rv_eff && dropping) drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        resp_pc <= resp_pc + 64'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: in-order variable-latency memory model,
// scoreboard of expected PCs consumed as the ID side accepts instructions.
module tb_fetch_queue_unit;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'hD503201F;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_gnt = 1'b1, imem_rvalid = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0, id_stall = 1'b1;
  logic [63:0] redirect_addr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pcaddr;

  int     tests = 0, fails = 0;
  int     lat = 1;
  bit     hold = 1'b1;
  longint cyc = 0;

  typedef struct { logic [63:0] addr; longint due; } req_t;
  req_t        mq[$];
  logic [63:0] sb[$];

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr), .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pcaddr(if_pcaddr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: samples the handshake at the edge, presents the next response 1ns later.
  always @(posedge clk) begin
    if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
    if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: cyc + longint'(lat)});
    cyc++;
    #1;
    if (rst) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // ID side: accepts only while expected entries remain, checks each accepted one.
  always @(posedge clk) begin
    logic [63:0] e;
    #3;
    id_stall = hold || (sb.size() == 0);
    if (!rst && !redirect && if_valid && !id_stall) begin
      e = sb.pop_front();
      chk("out_pc", if_pcaddr, e);
      chk("out_instr", {32'h0, if_instr}, {32'h0, instr_of(e)});
    end
  end

  always @(posedge clk) begin
    if (dut.push) begin
      tests++;
      assert (dut.count != 3'(DEPTH)) else begin
        fails++;
        $error("FAIL fifo_overflow: observed count %0d expected below %0d", dut.count, DEPTH);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(string tag, int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s: observed %0d entries missing expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    hold = 1'b1;
    rst  = 1'b1;
    step(2);
    rst  = 1'b0;
  endtask

  initial begin
    // Reset state and first-fetch latency with a 1-cycle memory
    lat = 1;
    hold = 1'b1;
    step(2);
    chk("rst_valid", {63'h0, if_valid}, 64'd0);
    chk("rst_instr", {32'h0, if_instr}, {32'h0, NOP});
    chk("rst_pcaddr", if_pcaddr, 64'h0);
    chk("rst_req", {63'h0, imem_req}, 64'd0);
    rst = 1'b0;
    #1;
    chk("req_after_rst", {63'h0, imem_req}, 64'd1);
    chk("addr_after_rst", imem_addr, RESET_PC);
    for (int i = 0; i < 6; i++) sb.push_back(RESET_PC + 64'(4 * i));
    hold = 1'b0;
    step(1);
    chk("lat_c1_valid", {63'h0, if_valid}, 64'd0);
    step(1);
    chk("lat_c2_valid", {63'h0, if_valid}, 64'd1);
    chk("lat_c2_pc", if_pcaddr, RESET_PC);
    drain("seq_l1", 40);

    // Long ID stall: FIFO fills, fetch stops, head holds
    do_reset();
    step(10);
    chk("stall_valid", {63'h0, if_valid}, 64'd1);
    chk("stall_pc", if_pcaddr, RESET_PC);
    chk("stall_instr", {32'h0, if_instr}, {32'h0, instr_of(RESET_PC)});
    chk("stall_req", {63'h0, imem_req}, 64'd0);
    chk("stall_count", 64'(dut.count), 64'(DEPTH));
    step(3);
    chk("stall_pc_hold", if_pcaddr, RESET_PC);
    chk("stall_req_hold", {63'h0, imem_req}, 64'd0);
    for (int i = 0; i < 8; i++) sb.push_back(RESET_PC + 64'(4 * i));
    hold = 1'b0;
    drain("stall_release", 40);

    // Redirect with 3 requests in flight, latency 4
    lat = 4;
    do_reset();
    step(3);
    chk("out3", 64'(dut.outstanding), 64'd3);
    chk("no_rv", {63'h0, imem_rvalid}, 64'd0);
    redirect = 1'b1;
    redirect_addr = 64'h100;
    #1;
    chk("req_in_redirect", {63'h0, imem_req}, 64'd0);
    step(1);
    redirect = 1'b0;
    chk("drop3", 64'(dut.drop_cnt), 64'd3);
    chk("redir_valid", {63'h0, if_valid}, 64'd0);
    #1;
    chk("redir_addr", imem_addr, 64'h100);
    sb.push_back(64'h100); sb.push_back(64'h104); sb.push_back(64'h108);
    hold = 1'b0;
    drain("redir_l4", 80);

    // Redirect coinciding with a response, one more outstanding
    lat = 2;
    do_reset();
    step(2);
    chk("rv_now", {63'h0, imem_rvalid}, 64'd1);
    chk("out2", 64'(dut.outstanding), 64'd2);
    redirect = 1'b1;
    redirect_addr = 64'h200;
    step(1);
    redirect = 1'b0;
    chk("drop1", 64'(dut.drop_cnt), 64'd1);
    chk("out1", 64'(dut.outstanding), 64'd1);
    sb.push_back(64'h200); sb.push_back(64'h204);
    hold = 1'b0;
    drain("redir_rv", 60);

    // Misaligned redirect target is forced to a word boundary
    hold = 1'b1;
    redirect = 1'b1;
    redirect_addr = 64'h103;
    step(1);
    redirect = 1'b0;
    #1;
    chk("align_addr", imem_addr, 64'h100);
    for (int i = 0; i < 4; i++) sb.push_back(64'h100 + 64'(4 * i));
    hold = 1'b0;
    drain("align_seq", 60);

    // Reset mid-stream with the FIFO half full
    lat = 1;
    hold = 1'b1;
    redirect = 1'b1;
    redirect_addr = 64'h400;
    step(1);
    redirect = 1'b0;
    step(3);
    chk("half_count", 64'(dut.count), 64'd2);
    rst = 1'b1;
    step(1);
    chk("rst2_valid", {63'h0, if_valid}, 64'd0);
    chk("rst2_instr", {32'h0, if_instr}, {32'h0, NOP});
    chk("rst2_pcaddr", if_pcaddr, 64'h0);
    chk("rst2_addr", imem_addr, RESET_PC);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back(RESET_PC + 64'(4 * i));
    hold = 1'b0;
    drain("post_rst", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
